// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, instruction formats and packing helpers for the instruction encoder.
package instr_encoder_pkg;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpShl = 4'd5;
    localparam logic [3:0] OpShr = 4'd6;
    localparam logic [3:0] OpCmp = 4'd7;
    localparam logic [3:0] OpLi  = 4'd8;
    localparam logic [3:0] OpMul = 4'd9;
    localparam logic [3:0] OpDiv = 4'd10;
    localparam logic [3:0] OpBiz = 4'd11;
    localparam logic [3:0] OpBnz = 4'd12;
    localparam logic [3:0] OpLd  = 4'd13;
    localparam logic [3:0] OpSt  = 4'd14;
    localparam logic [3:0] OpJr  = 4'd15;

    typedef enum logic [1:0] {FmtR, FmtI, FmtB, FmtJ} fmt_e;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    function automatic fmt_e op_format(input logic [3:0] op);
        fmt_e fmt;
        unique case (op)
            OpLi, OpLd, OpSt: fmt = FmtI;
            OpBiz, OpBnz:     fmt = FmtB;
            OpJr:             fmt = FmtJ;
            default:          fmt = FmtR;
        endcase
        return fmt;
    endfunction

    // Fields a format does not consume are dropped, so the word never carries stray bits.
    function automatic logic [15:0] pack_word(input logic [3:0] op, input logic [3:0] dr,
                                              input logic [3:0] sa, input logic [3:0] sb,
                                              input logic [7:0] imm);
        logic [15:0] word;
        unique case (op_format(op))
            FmtI:    word = {op, dr, imm};
            FmtB:    word = {op, sa, imm};
            FmtJ:    word = {op, dr, sa, 4'h0};
            default: word = {op, dr, sa, sb};
        endcase
        return word;
    endfunction

    function automatic logic unused_nonzero(input logic [3:0] op, input logic [3:0] dr,
                                            input logic [3:0] sa, input logic [3:0] sb,
                                            input logic [7:0] imm);
        logic bad;
        unique case (op_format(op))
            FmtI:    bad = (sa != 4'h0) || (sb != 4'h0);
            FmtB:    bad = (dr != 4'h0) || (sb != 4'h0);
            FmtJ:    bad = (sb != 4'h0) || (imm != 8'h00);
            default: bad = (imm != 8'h00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous word FIFO with flush; pointers carry an extra wrap bit to tell full from empty.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush) mem[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 16-bit words and streams them to instruction memory.
// Define ENC_STRICT_EN to reject (and flag via err) words with nonzero unused fields.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        dr,
    input  logic [3:0]        sa,
    input  logic [3:0]        sb,
    input  logic [7:0]        immediate,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              ovf,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrMax  = '1;
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic        accept, push, err_set, wr_done;
    logic        fifo_full, fifo_empty;
    logic [15:0] fifo_rdata, packed_word;

    assign packed_word = pack_word(opcode, dr, sa, sb, immediate);
    assign in_ready    = (state_q == StLoad) && !fifo_full && !start;
    assign accept      = in_valid && in_ready;

`ifdef ENC_STRICT_EN
    logic bad_fields;
    assign bad_fields = unused_nonzero(opcode, dr, sa, sb, immediate);
    assign push       = accept && !bad_fields;
    assign err_set    = accept && bad_fields;
`else
    assign push       = accept;
    assign err_set    = 1'b0;
`endif

    // Output is driven straight off FIFO occupancy, so an async reset drops mem_we immediately.
    assign mem_we     = !fifo_empty && !start;
    assign mem_wdata  = fifo_empty ? 16'h0000 : fifo_rdata;
    assign wr_done    = mem_we && mem_ready;
    assign mem_addr   = mem_addr_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign done       = (state_q == StDone);

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (push),
        .pop   (wr_done),
        .wdata (packed_word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = StLoad;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StIdle;
                StLoad:  if (accept && in_last) state_d = StDrain;
                StDrain: if (fifo_empty) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        if (start) begin
            mem_addr_d   = BaseAddr;
            word_count_d = '0;
            err_d        = 1'b0;
            ovf_d        = 1'b0;
        end else begin
            if (wr_done) begin
                mem_addr_d   = mem_addr_q + AddrOne;
                word_count_d = word_count_q + CountOne;
                if (mem_addr_q == AddrMax) ovf_d = 1'b1;
            end
            if (err_set) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mem_addr_q   <= BaseAddr;
            word_count_q <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder: driver queues expected words, monitor checks writes.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int BASE   = 2;
    localparam int NADDR  = 1 << ADDR_W;
`ifdef ENC_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic mem_ready = 1'b0;
    logic [3:0] opcode = '0, dr = '0, sa = '0, sb = '0;
    logic [7:0] immediate = '0;
    logic in_ready, mem_we, done, err, ovf;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [ADDR_W:0] word_count;

    int checks = 0;
    int failures = 0;
    int rdy_mode = 2;  // 0 random, 1 held low, 2 held high
    int n_pushed = 0;
    bit any_bad = 1'b0;
    logic [15:0] exp_q[$];

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .dr         (dr),
        .sa         (sa),
        .sb         (sb),
        .immediate  (immediate),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .done       (done),
        .err        (err),
        .ovf        (ovf),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packing from the format table, in plain arithmetic.
    function automatic logic [15:0] model_word(input int op, input int d, input int a,
                                               input int b, input int imm);
        int w;
        case (op)
            8, 13, 14: w = d * 256 + imm;
            11, 12:    w = a * 256 + imm;
            15:        w = d * 256 + a * 16;
            default:   w = d * 256 + a * 16 + b;
        endcase
        w = op * 4096 + w;
        return 16'(w);
    endfunction

    function automatic bit model_bad(input int op, input int d, input int a, input int b,
                                     input int imm);
        case (op)
            8, 13, 14: return (a != 0) || (b != 0);
            11, 12:    return (d != 0) || (b != 0);
            15:        return (b != 0) || (imm != 0);
            default:   return imm != 0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       mem_ready = ($urandom % 4) != 0;
                1:       mem_ready = 1'b0;
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops one expectation per completed write and checks address order and stalls.
    initial begin
        int widx;
        bit stall;
        logic [15:0] sd;
        logic [ADDR_W-1:0] sad;
        logic [15:0] e;
        widx = 0;
        stall = 1'b0;
        sd = '0;
        sad = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || start) begin
                widx = 0;
                stall = 1'b0;
            end else begin
                if (stall && mem_we) begin
                    check("wdata_stable", 32'(mem_wdata), 32'(sd));
                    check("addr_stable", 32'(mem_addr), 32'(sad));
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got wdata 0x%0h addr 0x%0h expected none",
                                 mem_wdata, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", 32'(mem_wdata), 32'(e));
                        check("addr", 32'(mem_addr), 32'((BASE + widx) % NADDR));
                    end
                    widx++;
                    stall = 1'b0;
                end else begin
                    stall = mem_we;
                    sd = mem_wdata;
                    sad = mem_addr;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        in_valid = 1'($urandom % 2);
        @(negedge clk);
        check("in_ready_on_start", 32'(in_ready), 32'(0));
        @(posedge clk);
        exp_q.delete();
        n_pushed = 0;
        any_bad = 1'b0;
        #1;
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input int op, input int d, input int a, input int b, input int imm,
                        input bit last);
        bit acc;
        acc = 1'b0;
        opcode = 4'(op);
        dr = 4'(d);
        sa = 4'(a);
        sb = 4'(b);
        immediate = 8'(imm);
        in_last = last;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                if (!(STRICT && model_bad(op, d, a, b, imm))) begin
                    exp_q.push_back(model_word(op, d, a, b, imm));
                    n_pushed++;
                end
                if (model_bad(op, d, a, b, imm)) any_bad = 1'b1;
            end
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready 0 expected acceptance within 300 cycles");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            seen = done;
        end
        check("done_reached", 32'(seen), 32'(1));
        check("word_count", 32'(word_count), 32'(n_pushed));
        check("ovf", 32'(ovf), 32'((BASE + n_pushed) >= NADDR));
        check("err", 32'(err), 32'(STRICT && any_bad));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        check("we_idle_in_done", 32'(mem_we), 32'(0));
        check("in_ready_in_done", 32'(in_ready), 32'(0));
        tick();
    endtask

    task automatic run_random(input int n);
        int op, d, a, b, imm;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            op = $urandom % 16;
            d = $urandom % 16;
            a = $urandom % 16;
            b = $urandom % 16;
            imm = $urandom % 256;
            if (($urandom % 3) != 0) begin
                case (op)
                    8, 13, 14: begin a = 0; b = 0; end
                    11, 12:    begin d = 0; b = 0; end
                    15:        begin b = 0; imm = 0; end
                    default:   imm = 0;
                endcase
            end
            send(op, d, a, b, imm, i == n - 1);
            repeat ($urandom % 3) tick();
        end
        wait_done();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_word_count", 32'(word_count), 32'(0));
        rst_n = 1'b1;
        tick();

        // First word appears on the memory port one cycle after acceptance.
        rdy_mode = 2;
        pulse_start();
        send(0, 1, 2, 3, 0, 1'b0);
        @(negedge clk);
        check("first_we", 32'(mem_we), 32'(1));
        check("first_wdata", 32'(mem_wdata), 32'(16'h0123));
        check("first_addr", 32'(mem_addr), 32'(BASE));
        tick();
        send(8, 4, 15, 0, 8'hA5, 1'b0);
        send(11, 15, 2, 0, 8'h10, 1'b1);
        wait_done();

        // Backpressure: FIFO fills, in_ready drops, fifth word waits.
        rdy_mode = 1;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) send(i, i + 1, i + 2, i + 3, 0, 1'b0);
        @(negedge clk);
        check("in_ready_full", 32'(in_ready), 32'(0));
        tick();
        rdy_mode = 2;
        send(9, 5, 6, 7, 0, 1'b1);
        wait_done();

        // Jump word with a stray sb field.
        pulse_start();
        send(15, 1, 2, 7, 0, 1'b1);
        wait_done();

        // Restart while draining three queued words.
        rdy_mode = 1;
        tick();
        pulse_start();
        for (int i = 0; i < 3; i++) send(1, i, i, i, 0, i == 2);
        pulse_start();
        @(negedge clk);
        check("restart_we", 32'(mem_we), 32'(0));
        check("restart_addr", 32'(mem_addr), 32'(BASE));
        check("restart_in_ready", 32'(in_ready), 32'(1));
        check("restart_count", 32'(word_count), 32'(0));
        check("restart_done", 32'(done), 32'(0));
        tick();
        rdy_mode = 0;
        send(2, 3, 4, 5, 0, 1'b0);
        send(13, 6, 0, 0, 8'h3C, 1'b1);
        wait_done();

        for (int p = 0; p < 12; p++) run_random($urandom_range(1, 20));

        // Async reset while a write is stalled.
        rdy_mode = 1;
        tick();
        pulse_start();
        send(3, 1, 1, 1, 0, 1'b0);
        send(4, 2, 2, 2, 0, 1'b0);
        @(negedge clk);
        check("pre_reset_we", 32'(mem_we), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_we", 32'(mem_we), 32'(0));
        check("async_reset_addr", 32'(mem_addr), 32'(BASE));
        check("async_reset_ready", 32'(in_ready), 32'(0));
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rdy_mode = 0;
        run_random(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, word FIFO entries (power of 2, >=2).
REQ-002 Parameter: ADDR_W, 8, instruction-memory address width.
REQ-003 Parameter: BASE_ADDR, 0, first load address.
REQ-004 One clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a new program load.
REQ-008 in_valid / in_ready  in / out  1 / 1  field-input handshake.
REQ-009 opcode, dr, sa, sb  in  4 each  instruction fields.
REQ-010 immediate  in  8  immediate field.
REQ-011 in_last  in  1  marks the final instruction of the program.
REQ-012 mem_we / mem_ready  out / in  1 / 1  memory-write handshake.
REQ-013 mem_addr, mem_wdata  out  ADDR_W, 16  write address and packed word.
REQ-014 done, err, ovf  out  1 each  load complete, strict-field error (sticky), address wrap (sticky).
REQ-015 word_count  out  ADDR_W+1  words written since start.

Function
REQ-016 Packing SHALL place opcode in [15:12] and use the following per-opcode formats.
REQ-017 R format, opcodes 0-7, 9 and 10: dr in [11:8], sa in [7:4], sb in [3:0].
REQ-018 I format, opcodes 8, 13 and 14: dr in [11:8], immediate in [7:0].
REQ-019 B format, opcodes 11 and 12: sa in [11:8], immediate in [7:0].
REQ-020 J format, opcode 15: dr in [11:8], sa in [7:4], [3:0] = 0000.
REQ-021 Field bits that a format does not use SHALL be forced to zero (no X is ever emitted).
REQ-022 FSM states SHALL be IDLE, LOAD, DRAIN and DONE.
REQ-023 FSM transitions SHALL be: IDLE->LOAD on start; LOAD->DRAIN on acceptance of an in_last word; DRAIN->DONE when the FIFO is empty and no write is pending; DONE->LOAD on start.
REQ-024 in_ready SHALL be 1 only in LOAD with the FIFO not full; a simultaneous pop does not free a full slot.
REQ-025 An accepted word SHALL be pushed on the accepting edge, and mem_we SHALL assert no earlier than the next cycle (latency 1).
REQ-026 mem_we SHALL assert whenever the FIFO is non-empty, and mem_addr/mem_wdata SHALL hold stable until mem_we&&mem_ready.
REQ-027 On each completed write, the FIFO SHALL pop, mem_addr SHALL increment and word_count SHALL increment.
REQ-028 When mem_addr reaches 2^ADDR_W-1 and completes a write, it SHALL wrap to 0 and set ovf.
REQ-029 start in any state SHALL flush the FIFO, deassert mem_we, load mem_addr=BASE_ADDR, clear word_count, err, ovf and done, and enter LOAD.
REQ-030 On a start cycle, in_valid SHALL be ignored and in_ready SHALL be 0.
REQ-031 done SHALL be high only in DONE.

Reset
REQ-032 Reset SHALL force state=IDLE and an empty FIFO.
REQ-033 Reset values SHALL be: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err=0, ovf=0, word_count=0.
REQ-034 Reset asserted mid-write SHALL abandon the write, and mem_we SHALL fall asynchronously.

Configuration
REQ-035 The macro SHALL be ENC_STRICT_EN.
REQ-036 With ENC_STRICT_EN defined, an accepted word with nonzero unused fields SHALL set err and SHALL NOT be pushed, while in_last on that word still ends LOAD.
REQ-037 Without ENC_STRICT_EN, unused fields SHALL be masked and err SHALL stay 0.

Structure
REQ-038 Shared package SHALL hold opcode constants (ADD..JR), a format enum (R, I, B, J) and the opcode-to-format function.
REQ-039 A single sub-module, enc_fifo (sync FIFO, push/pop/full/empty), SHALL be used.

Verification
REQ-040 Reset, then start, then in_valid with op=0,dr=1,sa=2,sb=3 and mem_ready=1 -> next cycle mem_we=1, mem_addr=0x00, mem_wdata=16'h0123.
REQ-041 In LOAD, send LI dr=4 imm=8'hA5 with sa=F, then BIZ sa=2 imm=8'h10 with dr=F -> writes 16'h84A5 and 16'hB210.
REQ-042 Hold mem_ready=0 and push 5 words -> in_ready falls after 4 and wdata stays stable; then release mem_ready -> 4 ordered writes, then the 5th is accepted.
REQ-043 Use ADDR_W=2 and send 5 words, the last with in_last -> addresses 0,1,2,3,0 and ovf=1; done=1 after the final write and word_count=5.
REQ-044 With ENC_STRICT_EN, send JR dr=1 sa=2 sb=7 -> err=1 and no write; without the macro -> write 16'hF120, err=0.
REQ-045 Pulse start mid-DRAIN with 3 words queued -> mem_we=0 next cycle, FIFO empty, mem_addr=BASE_ADDR, state LOAD.
